// File: rtl/gtob_stream.sv
// Streaming Gray-to-binary decoder with a 2-stage valid/ready pipeline.
// Flags and counts accepted Gray words that jump more than one bit from their predecessor.
module gtob_stream #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             g_valid,
  output logic             g_ready,
  input  logic [WIDTH-1:0] g,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Fold from the MSB down: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gv);
    logic [WIDTH-1:0] bv;
    bv[WIDTH-1] = gv[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      bv[i] = bv[i+1] ^ gv[i];
    end
    return bv;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_bit(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] xm1;
    xm1 = x - WIDTH'(1);
    return (x & xm1) != '0;
  endfunction

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic             s1_err_q, s1_err_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_b_q, s2_b_d;
  logic             s2_err_q, s2_err_d;
  logic [WIDTH-1:0] prev_g_q, prev_g_d;
  logic             have_prev_q, have_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s2_rdy;
  logic s1_rdy;
  logic accept;
  logic deliver;

  always_comb begin
    s2_rdy  = ~s2_v_q | b_ready;
    s1_rdy  = ~s1_v_q | s2_rdy;
    accept  = g_valid & s1_rdy;
    deliver = s2_v_q & b_ready;
  end

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_g_d      = s1_g_q;
    s1_err_d    = s1_err_q;
    s2_v_d      = s2_v_q;
    s2_b_d      = s2_b_q;
    s2_err_d    = s2_err_q;
    prev_g_d    = prev_g_q;
    have_prev_d = have_prev_q;
    cnt_d       = cnt_q;

    if (s1_rdy) begin
      s1_v_d = g_valid;
    end
    if (accept) begin
      s1_g_d      = g;
      s1_err_d    = have_prev_q & multi_bit(g ^ prev_g_q);
      prev_g_d    = g;
      have_prev_d = 1'b1;
    end

    if (s2_rdy) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_b_d   = gray2bin(s1_g_q);
        s2_err_d = s1_err_q;
      end
    end

    // Only the word leaving the block this cycle affects the count.
    if (deliver && s2_err_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_g_q      <= '0;
      s1_err_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_b_q      <= '0;
      s2_err_q    <= 1'b0;
      prev_g_q    <= '0;
      have_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_g_q      <= s1_g_d;
      s1_err_q    <= s1_err_d;
      s2_v_q      <= s2_v_d;
      s2_b_q      <= s2_b_d;
      s2_err_q    <= s2_err_d;
      prev_g_q    <= prev_g_d;
      have_prev_q <= have_prev_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    g_ready  = s1_rdy;
    b_valid  = s2_v_q;
    b        = s2_b_q;
    step_err = s2_err_q;
    err_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_gtob_stream.sv
// Randomised and directed bench for gtob_stream, checked every cycle against a queue-based
// model of the decoder and its step checker.
module tb_gtob_stream;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned CNT_W = 8;
  localparam int CntMax = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             g_valid;
  logic             g_ready;
  logic [WIDTH-1:0] g;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b;
  logic             step_err;
  logic [CNT_W-1:0] err_cnt;

  gtob_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .g_valid  (g_valid),
    .g_ready  (g_ready),
    .g        (g),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b        (b),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic             err;
    int               stamp;
  } item_t;

  item_t            mq[$];
  logic [WIDTH-1:0] m_prev;
  logic             m_have;
  int               m_cnt;
  int               cyc = 0;
  logic [WIDTH-1:0] log_b[$];
  logic             log_e[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Binary is the XOR of the Gray word with all of its right shifts.
  function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    for (int s = 1; s < int'(WIDTH); s++) r = r ^ (w >> s);
    return r;
  endfunction

  // Compare on the falling edge, then advance the model to what the next rising edge does.
  always @(negedge clk) begin
    logic exp_bv, exp_gr;
    if (!rst_n) begin
      mq.delete();
      m_prev = '0;
      m_have = 1'b0;
      m_cnt  = 0;
    end else begin
      exp_bv = (mq.size() > 0) && (cyc >= mq[0].stamp + 2);
      exp_gr = (mq.size() < 2) || b_ready;
      chk("b_valid", 32'(b_valid), 32'(exp_bv));
      chk("g_ready", 32'(g_ready), 32'(exp_gr));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (exp_bv) begin
        chk("b", 32'(b), 32'(mq[0].bin));
        chk("step_err", 32'(step_err), 32'(mq[0].err));
        if (b_ready) begin
          if (mq[0].err && m_cnt < CntMax) m_cnt++;
          log_b.push_back(mq[0].bin);
          log_e.push_back(mq[0].err);
          void'(mq.pop_front());
        end
      end
      if (g_valid && exp_gr) begin
        item_t it;
        it.bin   = to_bin(g);
        it.err   = m_have && ($countones(g ^ m_prev) > 1);
        it.stamp = cyc;
        mq.push_back(it);
        m_prev = g;
        m_have = 1'b1;
      end
    end
    cyc++;
  end

  task automatic put(input logic [WIDTH-1:0] w);
    logic acc;
    int   n;
    n = 0;
    g_valid = 1'b1;
    g = w;
    forever begin
      @(negedge clk);
      acc = g_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        chk("put_timeout", 32'd1, 32'd0);
        break;
      end
    end
    g_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
  endtask

  task automatic clear_log();
    log_b.delete();
    log_e.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] last_g;
    logic [WIDTH-1:0] sweep[8];
    rst_n   = 1'b0;
    g_valid = 1'b0;
    g       = '0;
    b_ready = 1'b1;
    #1;
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full Gray sweep decodes to 0..7 with no flags.
    sweep = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    clear_log();
    for (int i = 0; i < 8; i++) put(sweep[i]);
    drain();
    chk("sweep_count", 32'(log_b.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_b.size(); i++) begin
      chk("sweep_b", 32'(log_b[i]), 32'(i));
      chk("sweep_err", 32'(log_e[i]), 32'd0);
    end
    chk("sweep_err_cnt", 32'(err_cnt), 32'd0);

    // 100 -> 000 wraps legally, 000 -> 011 is a two-bit jump.
    clear_log();
    put(3'b000);
    put(3'b011);
    drain();
    @(negedge clk);
    chk("jump_count", 32'(log_b.size()), 32'd2);
    if (log_b.size() == 2) begin
      chk("jump_b0", 32'(log_b[0]), 32'd0);
      chk("jump_b1", 32'(log_b[1]), 32'd2);
      chk("jump_e1", 32'(log_e[1]), 32'd1);
    end
    chk("jump_err_cnt", 32'(err_cnt), 32'd1);

    // Six words against a five-cycle stall.
    @(posedge clk);
    #1;
    clear_log();
    fork
      begin
        for (int i = 0; i < 6; i++) put(WIDTH'(i));
      end
      begin
        b_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 b_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(log_b.size()), 32'd6);

    // Random traffic, mostly single-bit steps with occasional jumps and repeats.
    last_g = '0;
    for (int c = 0; c < 2000; c++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      if (r == 0) last_g = WIDTH'($urandom);
      else if (r >= 2) last_g = last_g ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      g       = last_g;
      g_valid = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    g_valid = 1'b0;
    b_ready = 1'b1;
    drain();

    // Reset with two words held under backpressure.
    b_ready = 1'b0;
    put(3'b011);
    put(3'b110);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_b_valid", 32'(b_valid), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b_ready = 1'b1;
    #1;
    chk("midrst_g_ready", 32'(g_ready), 32'd1);

    // First word after reset never flags; a repeat is legal.
    clear_log();
    put(3'b101);
    put(3'b101);
    drain();
    chk("rep_count", 32'(log_b.size()), 32'd2);
    for (int i = 0; i < 2 && i < log_b.size(); i++) begin
      chk("rep_b", 32'(log_b[i]), 32'd6);
      chk("rep_err", 32'(log_e[i]), 32'd0);
    end

    // Every word after the first is a three-bit jump; the counter must stop at its ceiling.
    for (int i = 0; i < 300; i++) put((i % 2 == 0) ? 3'b000 : 3'b111);
    drain();
    @(negedge clk);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
